// File: rtl/game_progress_if.sv
// ---------------------------------------------------------------------------
// game_progress_if
// Purpose : Bundles the player-stage inputs and the level/lives/display
//           outputs of the game progress block into a single interface.
// Signals : i_player_x   [4:0] player column (debug / hit checker only)
//           i_player_y   [3:0] player row, 0..14
//           i_hit              one-cycle collision pulse
//           o_level_tens [3:0] BCD tens digit of level
//           o_level_ones [3:0] BCD ones digit of level
//           o_lives      [1:0] remaining lives
//           o_state      [1:0] 00 PLAYING, 01 DYING, 10 GAME_OVER
//           o_respawn          one-cycle respawn request
//           o_seg_tens   [6:0] active-low segments {g,f,e,d,c,b,a}, tens
//           o_seg_ones   [6:0] active-low segments {g,f,e,d,c,b,a}, ones
// Modports: master drives the player inputs, slave is the progress block.
// ---------------------------------------------------------------------------
interface game_progress_if;
    logic [4:0] i_player_x;
    logic [3:0] i_player_y;
    logic       i_hit;
    logic [3:0] o_level_tens;
    logic [3:0] o_level_ones;
    logic [1:0] o_lives;
    logic [1:0] o_state;
    logic       o_respawn;
    logic [6:0] o_seg_tens;
    logic [6:0] o_seg_ones;

    modport master (
        output i_player_x, i_player_y, i_hit,
        input  o_level_tens, o_level_ones, o_lives, o_state, o_respawn,
               o_seg_tens, o_seg_ones
    );

    modport slave (
        input  i_player_x, i_player_y, i_hit,
        output o_level_tens, o_level_ones, o_lives, o_state, o_respawn,
               o_seg_tens, o_seg_ones
    );
endinterface

// File: rtl/game_progress.sv
// ---------------------------------------------------------------------------
// game_progress
// Purpose : Tracks the BCD level (00..99), remaining lives and the game FSM
//           (PLAYING / DYING / GAME_OVER), requests player respawn after a
//           death, and drives two 7-segment digits with the level.
// Ports   : i_Clk    system clock, rising edge
//           i_reset  synchronous, active-high reset
//           bus      game_progress_if.slave (player inputs, status outputs)
// Latency : inputs -> level/state 1 clock; level -> segments 1 more clock.
// ---------------------------------------------------------------------------
module game_progress #(
    parameter int START_LIVES  = 3,
    parameter int DEATH_CYCLES = 25000000,
    parameter int GOAL_ROW     = 0,
    parameter int ORIGIN_Y     = 14
) (
    input  logic               i_Clk,
    input  logic               i_reset,
    game_progress_if.slave     bus
);

    localparam int          CNT_W      = (DEATH_CYCLES > 2) ? $clog2(DEATH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_CYCLES - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0]  GOAL_Y     = 4'(GOAL_ROW);
    localparam logic [3:0]  ORIGIN_YV  = 4'(ORIGIN_Y);
    localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

    typedef enum logic [1:0] {
        ST_PLAYING   = 2'b00,
        ST_DYING     = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_e;

    state_e           state_q;
    logic [3:0]       level_tens_q, level_ones_q;
    logic [3:0]       level_tens_d, level_ones_d;
    logic [1:0]       lives_q;
    logic [CNT_W-1:0] death_cnt_q;
    logic [3:0]       prev_y_q;
    logic             respawn_q;
    logic [6:0]       seg_tens_q, seg_ones_q;
    logic             goal_event;

    // Column is only carried through for the hit checker / debug.
    logic unused_player_x;
    assign unused_player_x = ^bus.i_player_x;

    // Active-low {g,f,e,d,c,b,a}; anything that is not a BCD digit is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        // NOTE: the default arm gives every input value a defined result, so
        // no latch or X can appear for non-BCD codes.
        case (digit)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // The player stage holds y at the goal row for a single cycle, so only
    // the arrival edge counts as a crossing.
    assign goal_event = (bus.i_player_y == GOAL_Y) && (prev_y_q != GOAL_Y);

    // BCD increment with saturation at 99.
    always_comb begin
        level_tens_d = level_tens_q;
        level_ones_d = level_ones_q;
        if (!(level_tens_q == 4'd9 && level_ones_q == 4'd9)) begin
            if (level_ones_q == 4'd9) begin
                level_ones_d = 4'd0;
                level_tens_d = level_tens_q + 4'd1;
            end else begin
                level_ones_d = level_ones_q + 4'd1;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            state_q      <= ST_PLAYING;
            level_tens_q <= 4'd0;
            level_ones_q <= 4'd0;
            lives_q      <= LIVES_INIT;
            death_cnt_q  <= '0;
            prev_y_q     <= ORIGIN_YV;
            respawn_q    <= 1'b0;
            seg_tens_q   <= SEG_ZERO;
            seg_ones_q   <= SEG_ZERO;
        end else begin
            prev_y_q   <= bus.i_player_y;
            respawn_q  <= 1'b0;
            // Decoded from the current level registers: one clock of lag.
            seg_tens_q <= seg_decode(level_tens_q);
            seg_ones_q <= seg_decode(level_ones_q);

            unique case (state_q)
                ST_PLAYING: begin
                    // Hit wins over a simultaneous goal; lives >= 1 here.
                    if (bus.i_hit) begin
                        state_q     <= ST_DYING;
                        death_cnt_q <= '0;
                        lives_q     <= lives_q - 2'd1;
                    end else if (goal_event) begin
                        level_tens_q <= level_tens_d;
                        level_ones_q <= level_ones_d;
                    end
                end
                ST_DYING: begin
                    death_cnt_q <= death_cnt_q + 1'b1;
                    if (death_cnt_q == DEATH_LAST) begin
                        if (lives_q == 2'd0) begin
                            state_q <= ST_GAME_OVER;
                        end else begin
                            state_q   <= ST_PLAYING;
                            respawn_q <= 1'b1;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    state_q <= ST_GAME_OVER;
                end
                default: begin
                    state_q <= ST_PLAYING;
                end
            endcase
        end
    end

    assign bus.o_level_tens = level_tens_q;
    assign bus.o_level_ones = level_ones_q;
    assign bus.o_lives      = lives_q;
    assign bus.o_state      = state_q;
    assign bus.o_respawn    = respawn_q;
    assign bus.o_seg_tens   = seg_tens_q;
    assign bus.o_seg_ones   = seg_ones_q;

endmodule

// File: tb/tb_game_progress.sv
// ---------------------------------------------------------------------------
// tb_game_progress
// Purpose : Self-checking bench for game_progress with DEATH_CYCLES = 4.
//           Each driven cycle pushes the expected post-edge outputs into a
//           queue; a monitor pops and compares after every rising edge.
//           Key points are also checked against hand-written constants.
// ---------------------------------------------------------------------------
module tb_game_progress;

    localparam int DC = 4;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] lives;
        logic [1:0] state;
        logic       resp;
        logic [6:0] seg_t;
        logic [6:0] seg_o;
    } exp_t;

    logic i_Clk   = 1'b0;
    logic i_reset = 1'b1;

    game_progress_if bus ();

    game_progress #(
        .START_LIVES (3),
        .DEATH_CYCLES(DC),
        .GOAL_ROW    (0),
        .ORIGIN_Y    (14)
    ) dut (
        .i_Clk  (i_Clk),
        .i_reset(i_reset),
        .bus    (bus.slave)
    );

    always #5 i_Clk = ~i_Clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Behavioural reference, written in integer terms.
    int         m_level, m_lives, m_state, m_cnt, m_prev;
    logic       m_resp;
    logic [6:0] m_seg_t, m_seg_o;

    task automatic model_step(input logic rst, input int y, input logic hit);
        bit goal;
        if (rst) begin
            m_level = 0; m_lives = 3; m_state = 0; m_cnt = 0;
            m_prev = 14; m_resp = 1'b0;
            m_seg_t = SEG_TBL[0]; m_seg_o = SEG_TBL[0];
        end else begin
            goal    = (y == 0) && (m_prev != 0);
            m_seg_t = SEG_TBL[m_level / 10];
            m_seg_o = SEG_TBL[m_level % 10];
            m_resp  = 1'b0;
            if (m_state == 0) begin
                if (hit) begin
                    m_state = 1; m_cnt = 0; m_lives = m_lives - 1;
                end else if (goal && m_level < 99) begin
                    m_level = m_level + 1;
                end
            end else if (m_state == 1) begin
                if (m_cnt == DC - 1) begin
                    if (m_lives == 0) m_state = 2;
                    else begin m_state = 0; m_resp = 1'b1; end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_prev = y;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic step(input logic rst, input int y, input logic hit);
        exp_t e;
        @(negedge i_Clk);
        i_reset        = rst;
        bus.i_player_y = 4'(y);
        bus.i_hit      = hit;
        bus.i_player_x = 5'(1 + (y % 20));
        model_step(rst, y, hit);
        e.tens  = 4'(m_level / 10);
        e.ones  = 4'(m_level % 10);
        e.lives = 2'(m_lives);
        e.state = 2'(m_state);
        e.resp  = m_resp;
        e.seg_t = m_seg_t;
        e.seg_o = m_seg_o;
        sb_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge i_Clk);
        #2;
    endtask

    task automatic goal_pair();
        step(1'b0, 1, 1'b0);
        step(1'b0, 0, 1'b0);
    endtask

    // Monitor: one expected entry per edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_Clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.o_level_tens !== e.tens || bus.o_level_ones !== e.ones ||
                    bus.o_lives !== e.lives || bus.o_state !== e.state ||
                    bus.o_respawn !== e.resp || bus.o_seg_tens !== e.seg_t ||
                    bus.o_seg_ones !== e.seg_o) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got lvl %h%h lives %0d st %0d resp %b seg %b/%b, expected lvl %h%h lives %0d st %0d resp %b seg %b/%b",
                             $time, bus.o_level_tens, bus.o_level_ones, bus.o_lives,
                             bus.o_state, bus.o_respawn, bus.o_seg_tens, bus.o_seg_ones,
                             e.tens, e.ones, e.lives, e.state, e.resp, e.seg_t, e.seg_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_player_x = 5'd1;
        bus.i_player_y = 4'd14;
        bus.i_hit      = 1'b0;

        // Reset then idle.
        step(1'b1, 14, 1'b0);
        step(1'b1, 14, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 14, 1'b0);
        after_edge();
        check("reset_level", {bus.o_level_tens, bus.o_level_ones}, 8'h00);
        check("reset_lives", 8'(bus.o_lives), 8'd3);
        check("reset_state", 8'(bus.o_state), 8'd0);
        check("reset_seg_t", 8'(bus.o_seg_tens), 8'(7'b1000000));
        check("reset_seg_o", 8'(bus.o_seg_ones), 8'(7'b1000000));
        check("reset_resp", 8'(bus.o_respawn), 8'd0);

        // Walk up the board 14 -> 0.
        for (int y = 13; y >= 0; y--) step(1'b0, y, 1'b0);
        after_edge();
        check("goal_level01", {bus.o_level_tens, bus.o_level_ones}, 8'h01);
        step(1'b0, 0, 1'b0);
        after_edge();
        check("goal_seg_one", 8'(bus.o_seg_ones), 8'(7'b1111001));
        step(1'b0, 0, 1'b0);
        after_edge();
        check("goal_held_once", {bus.o_level_tens, bus.o_level_ones}, 8'h01);
        step(1'b0, 14, 1'b0);

        // Hit, ignored second hit, respawn after four DYING cycles.
        step(1'b0, 14, 1'b1);
        after_edge();
        check("hit1_lives", 8'(bus.o_lives), 8'd2);
        check("hit1_state", 8'(bus.o_state), 8'd1);
        step(1'b0, 14, 1'b1);
        step(1'b0, 14, 1'b0);
        step(1'b0, 14, 1'b0);
        after_edge();
        check("dying_hold", 8'(bus.o_state), 8'd1);
        check("dying_lives", 8'(bus.o_lives), 8'd2);
        step(1'b0, 14, 1'b0);
        after_edge();
        check("respawn_hi", 8'(bus.o_respawn), 8'd1);
        check("respawn_state", 8'(bus.o_state), 8'd0);
        step(1'b0, 14, 1'b0);
        after_edge();
        check("respawn_lo", 8'(bus.o_respawn), 8'd0);

        // Two more deaths -> GAME_OVER, no respawn.
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 14, 1'b1);
            for (int c = 0; c < DC; c++) step(1'b0, 14, 1'b0);
            step(1'b0, 14, 1'b0);
        end
        after_edge();
        check("gameover_state", 8'(bus.o_state), 8'd2);
        check("gameover_lives", 8'(bus.o_lives), 8'd0);
        check("gameover_resp", 8'(bus.o_respawn), 8'd0);
        step(1'b0, 14, 1'b1);
        goal_pair();
        step(1'b0, 5, 1'b1);
        after_edge();
        check("gameover_absorb", {bus.o_state, bus.o_lives, bus.o_level_tens}, {2'd2, 2'd0, 4'd0});
        check("gameover_level", 8'(bus.o_level_ones), 8'd1);
        step(1'b1, 14, 1'b0);
        after_edge();
        check("rst_lives", 8'(bus.o_lives), 8'd3);
        check("rst_level", {bus.o_level_tens, bus.o_level_ones}, 8'h00);

        // Level counting, BCD carry and saturation.
        for (int g = 1; g <= 100; g++) begin
            goal_pair();
            if (g == 9 || g == 10 || g == 99 || g == 100) begin
                after_edge();
                case (g)
                    9:       check("level09", {bus.o_level_tens, bus.o_level_ones}, 8'h09);
                    10:      check("level10", {bus.o_level_tens, bus.o_level_ones}, 8'h10);
                    99:      check("level99", {bus.o_level_tens, bus.o_level_ones}, 8'h99);
                    default: check("level_sat", {bus.o_level_tens, bus.o_level_ones}, 8'h99);
                endcase
            end
        end

        // Hit and goal together at level 05, then reset mid-DYING.
        step(1'b1, 14, 1'b0);
        for (int g = 0; g < 5; g++) goal_pair();
        step(1'b0, 1, 1'b0);
        step(1'b0, 0, 1'b1);
        after_edge();
        check("hitgoal_level", {bus.o_level_tens, bus.o_level_ones}, 8'h05);
        check("hitgoal_lives", 8'(bus.o_lives), 8'd2);
        step(1'b0, 3, 1'b0);
        step(1'b1, 14, 1'b0);
        after_edge();
        check("middie_state", 8'(bus.o_state), 8'd0);
        check("middie_lives", 8'(bus.o_lives), 8'd3);
        check("middie_resp", 8'(bus.o_respawn), 8'd0);
        for (int i = 0; i < DC + 1; i++) step(1'b0, 14, 1'b0);
        after_edge();
        check("middie_no_resp", 8'(bus.o_respawn), 8'd0);

        @(negedge i_Clk);
        check("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_progress.md
Name: game_progress

Overview:
- Consumes the player grid position (x 5 bits, y 4 bits) produced by the player movement stage, plus a collision pulse from the car/lane overlap checker.
- Tracks level (0..99, BCD), remaining lives, and a game FSM (PLAYING / DYING / GAME_OVER).
- Emits a respawn request back to the player stage.
- Drives the board's two 7-segment digits with the current level.

Parameters:
- START_LIVES, 3, lives loaded at reset (1..3, fits o_lives).
- DEATH_CYCLES, 25000000, length of DYING state in clocks (1 s at 25 MHz); must be >= 2.
- GOAL_ROW, 0, player y value that counts as a successful crossing.
- ORIGIN_Y, 14, value loaded into the previous-y register at reset.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_player_x  in  5  player column, 1..20 (carried for debug/hit checker; not used in FSM decisions).
- i_player_y  in  4  player row, 0..14.
- i_hit  in  1  one-cycle collision pulse, level-sensitive per cycle.
- o_level_tens  out  4  BCD tens digit of level.
- o_level_ones  out  4  BCD ones digit of level.
- o_lives  out  2  remaining lives.
- o_state  out  2  00 PLAYING, 01 DYING, 10 GAME_OVER.
- o_respawn  out  1  one-cycle pulse requesting player return to origin.
- o_seg_tens  out  7  active-low segments {g,f,e,d,c,b,a} for tens digit.
- o_seg_ones  out  7  active-low segments for ones digit.

Behaviour:
- Reset (i_reset=1 at a clock edge, overrides everything, including mid-DYING):
  - level 00, o_lives=START_LIVES, state PLAYING, o_respawn=0.
  - death counter 0, r_prev_y=ORIGIN_Y.
  - both seg outputs = 7'b1000000 ("0").
- r_prev_y <= i_player_y every non-reset cycle.
- Goal event: i_player_y==GOAL_ROW && r_prev_y!=GOAL_ROW (rising detection; the player stage holds y=0 only one cycle).
- PLAYING:
  - i_hit=1 -> DYING next cycle, death counter cleared, o_lives decremented same edge.
  - Else goal event -> level BCD increment on that edge:
    - ones 9 -> 0 with tens+1.
    - Saturates at 99 (stays 99).
  - Hit and goal in the same cycle: hit has priority; level unchanged.
- DYING:
  - Counter increments each cycle; i_hit and goal events are ignored.
  - When counter == DEATH_CYCLES-1:
    - If o_lives==0 -> GAME_OVER, o_respawn stays 0.
    - Else -> PLAYING with o_respawn=1 for exactly that one following cycle.
- GAME_OVER: absorbing; all inputs ignored until i_reset. Level and lives hold.
- o_lives never underflows (decrement happens only from PLAYING, where lives >= 1 by construction).
- o_respawn is registered, high exactly 1 cycle per respawn, never high in GAME_OVER or during reset.
- 7-segment outputs:
  - Registered decode of the level digits, so segments lag the level registers by 1 cycle.
  - Digits 0-9 use standard patterns; non-BCD values display blank (7'b1111111).
- Latency:
  - Input-to-level and input-to-state: 1 clock.
  - Level-to-segment: 1 further clock.

Test Plan:
- Apply reset, then idle 5 cycles -> level 00, lives 3, state 00, segs 1000000/1000000, o_respawn 0.
- With DEATH_CYCLES=4, y stepped 14->13->...->0 over consecutive cycles -> level 01 one cycle after y=0; o_seg_ones=1111001 the following cycle. Holding y=0 for 3 cycles still counts only once.
- Hit pulse in PLAYING with DEATH_CYCLES=4 -> lives 2 and state 01 next cycle; second hit during DYING ignored; o_respawn high for exactly 1 cycle after 4 DYING cycles; state 00.
- Three hits, each allowed to complete DYING -> after third, lives 0 and state 10 with no o_respawn. Subsequent hits and goals change nothing; reset restores lives 3 and level 00.
- Drive 99 goal events -> level tens 9, ones 9. Event 100 keeps 99. Crossing 09->10 verified as tens 1, ones 0.
- Hit and goal in the same cycle at level 05 -> level stays 05, lives decremented. Assert i_reset mid-DYING -> PLAYING, lives 3, no respawn pulse.
